// File: rtl/duty_ramp_ctrl.sv
// Slew-limited duty-cycle controller feeding the PWM generator's duty input.
// Optional macro DUTY_RAMP_BYPASS_EN adds i_bypass for an immediate duty load on accept.
module duty_ramp_ctrl #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int STEP_HZ  = 1_000,
    parameter int STEP     = 1,
    parameter int MAX_DUTY = 100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_tgt_valid,
    output logic       o_tgt_ready,
    input  logic [7:0] i_tgt_duty,
    input  logic       i_abort,
`ifdef DUTY_RAMP_BYPASS_EN
    input  logic       i_bypass,
`endif
    output logic [7:0] o_duty_cycle,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_clamped
);

    localparam int TICK_DIV = CLK_FREQ / STEP_HZ;
    localparam int CNT_W    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [7:0] STEP_8 = 8'(STEP);
    localparam logic [7:0] MAX_8  = 8'(MAX_DUTY);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP_UP   = 2'd1,
        RAMP_DOWN = 2'd2
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_tgt;
    logic [7:0]       r_duty;
    logic             r_done;
    logic             r_clamped;

    logic             w_accept;
    logic             w_tick;
    logic             w_over;
    logic             w_bypass;
    logic [7:0]       w_tgt_c;
    logic [7:0]       w_step_up;
    logic [7:0]       w_step_dn;
    logic [7:0]       w_next;

    function automatic logic [7:0] clamp_tgt(input logic [7:0] d);
        if ({1'b0, d} > {1'b0, MAX_8})
            return MAX_8;
        return d;
    endfunction

    // Gaps are 9-bit so the min(STEP, gap) choice can never wrap.
    function automatic logic [7:0] step_up(input logic [7:0] duty, input logic [7:0] tgt);
        logic [8:0] gap;
        gap = {1'b0, tgt} - {1'b0, duty};
        if (gap > {1'b0, STEP_8})
            return duty + STEP_8;
        return tgt;
    endfunction

    function automatic logic [7:0] step_down(input logic [7:0] duty, input logic [7:0] tgt);
        logic [8:0] gap;
        gap = {1'b0, duty} - {1'b0, tgt};
        if (gap > {1'b0, STEP_8})
            return duty - STEP_8;
        return tgt;
    endfunction

`ifdef DUTY_RAMP_BYPASS_EN
    assign w_bypass = i_bypass;
`else
    assign w_bypass = 1'b0;
`endif

    assign o_tgt_ready = (r_state == IDLE);
    assign w_accept    = i_tgt_valid && o_tgt_ready;
    assign w_tick      = (r_cnt == CNT_LAST);
    assign w_over      = ({1'b0, i_tgt_duty} > {1'b0, MAX_8});
    assign w_tgt_c     = clamp_tgt(i_tgt_duty);
    assign w_step_up   = step_up(r_duty, r_tgt);
    assign w_step_dn   = step_down(r_duty, r_tgt);
    assign w_next      = (r_state == RAMP_UP) ? w_step_up : w_step_dn;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_tgt     <= '0;
            r_duty    <= '0;
            r_done    <= 1'b0;
            r_clamped <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_clamped <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_tgt     <= w_tgt_c;
                        r_clamped <= w_over;
                        r_cnt     <= '0;
                        if (w_bypass) begin
                            r_duty <= w_tgt_c;
                            r_done <= 1'b1;
                        end else if (w_tgt_c > r_duty) begin
                            r_state <= RAMP_UP;
                        end else if (w_tgt_c < r_duty) begin
                            r_state <= RAMP_DOWN;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                RAMP_UP, RAMP_DOWN: begin
                    // Abort outranks a coincident tick: the duty freezes where it is.
                    if (i_abort) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else if (w_tick) begin
                        r_cnt  <= '0;
                        r_duty <= w_next;
                        if (w_next == r_tgt) begin
                            r_state <= IDLE;
                            r_done  <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign o_duty_cycle = r_duty;
    assign o_busy       = (r_state != IDLE);
    assign o_done       = r_done;
    assign o_clamped    = r_clamped;

endmodule

// File: tb/tb_duty_ramp_ctrl.sv
// Directed bench for duty_ramp_ctrl with a time-based ramp model checked every cycle.
module tb_duty_ramp_ctrl;

    localparam int TICK_DIV = 10;
    localparam int STEP     = 5;
    localparam int MAXD     = 100;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tgt_valid = 1'b0;
    logic [7:0] tgt_duty = 8'd0;
    logic       abort = 1'b0;
    logic       tgt_ready;
    logic [7:0] duty_cycle;
    logic       busy;
    logic       done;
    logic       clamped;

    int checks = 0;
    int failures = 0;

    duty_ramp_ctrl #(
        .CLK_FREQ(1000),
        .STEP_HZ (100),
        .STEP    (STEP),
        .MAX_DUTY(MAXD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_tgt_valid (tgt_valid),
        .o_tgt_ready (tgt_ready),
        .i_tgt_duty  (tgt_duty),
        .i_abort     (abort),
`ifdef DUTY_RAMP_BYPASS_EN
        .i_bypass    (1'b0),
`endif
        .o_duty_cycle(duty_cycle),
        .o_busy      (busy),
        .o_done      (done),
        .o_clamped   (clamped)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: duty is a function of ticks elapsed since the accept edge.
    int m_duty = 0, m_start = 0, m_tgt = 0, m_acc = 0, cyc = 0;
    int m_k, m_dist, m_moved, m_req;
    bit m_ramp = 0, m_up = 0, m_done = 0, m_clamped = 0;

    initial begin
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                m_duty = 0; m_tgt = 0; m_ramp = 0; m_done = 0; m_clamped = 0; cyc = 0;
            end else begin
                m_done = 0;
                m_clamped = 0;
                if (!m_ramp) begin
                    if (tgt_valid) begin
                        m_req = int'(tgt_duty);
                        m_clamped = (m_req > MAXD);
                        m_tgt = (m_req > MAXD) ? MAXD : m_req;
                        if (m_tgt == m_duty) begin
                            m_done = 1;
                        end else begin
                            m_ramp = 1;
                            m_up = (m_tgt > m_duty);
                            m_start = m_duty;
                            m_acc = cyc;
                        end
                    end
                end else if (abort) begin
                    m_ramp = 0;
                end else begin
                    m_k = (cyc - m_acc) / TICK_DIV;
                    m_dist = m_up ? (m_tgt - m_start) : (m_start - m_tgt);
                    m_moved = (m_k * STEP < m_dist) ? m_k * STEP : m_dist;
                    m_duty = m_up ? (m_start + m_moved) : (m_start - m_moved);
                    if (m_moved == m_dist) begin
                        m_ramp = 0;
                        m_done = 1;
                    end
                end
                cyc++;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_duty", int'(duty_cycle), 0);
                chk("rst_busy", int'(busy), 0);
                chk("rst_done", int'(done), 0);
                chk("rst_clamped", int'(clamped), 0);
                chk("rst_ready", int'(tgt_ready), 1);
            end else begin
                chk("model_duty", int'(duty_cycle), m_duty);
                chk("model_busy", int'(busy), int'(m_ramp));
                chk("model_ready", int'(tgt_ready), int'(!m_ramp));
                chk("model_done", int'(done), int'(m_done));
                chk("model_clamped", int'(clamped), int'(m_clamped));
                chk("duty_le_max", int'(duty_cycle <= 8'(MAXD)), 1);
            end
        end
    end

    task automatic adv(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_accept(input int d);
        tgt_duty = 8'(d);
        tgt_valid = 1'b1;
        @(posedge clk);
        #1;
        tgt_valid = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int n);
        bit found;
        found = 0;
        n = 0;
        while (n < limit && !found) begin
            @(posedge clk);
            #1;
            n++;
            if (done) found = 1;
        end
        chk("done_seen", int'(found), 1);
    endtask

    int n;

    initial begin
        // Reset
        repeat (2) @(posedge clk);
        #1;
        chk("lit_rst_duty", int'(duty_cycle), 0);
        chk("lit_rst_busy", int'(busy), 0);
        chk("lit_rst_ready", int'(tgt_ready), 1);
        rst_n = 1'b1;
        adv(1);
        chk("lit_post_rst_duty", int'(duty_cycle), 0);
        chk("lit_post_rst_ready", int'(tgt_ready), 1);

        // 0 -> 20 with tgt_valid held while busy
        do_accept(20);
        chk("up20_busy_e0", int'(busy), 1);
        chk("up20_ready_e0", int'(tgt_ready), 0);
        adv(1);
        tgt_valid = 1'b1;
        tgt_duty = 8'd90;
        adv(9);
        chk("up20_e10", int'(duty_cycle), 5);
        adv(10);
        chk("up20_e20", int'(duty_cycle), 10);
        adv(10);
        chk("up20_e30", int'(duty_cycle), 15);
        adv(8);
        tgt_valid = 1'b0;
        adv(1);
        chk("up20_e39", int'(duty_cycle), 15);
        chk("up20_e39_done", int'(done), 0);
        adv(1);
        chk("up20_e40", int'(duty_cycle), 20);
        chk("up20_e40_done", int'(done), 1);
        chk("up20_e40_busy", int'(busy), 0);
        adv(1);
        chk("up20_e41_done", int'(done), 0);
        chk("up20_e41_duty", int'(duty_cycle), 20);

        // 20 -> 0, then equal target
        do_accept(0);
        adv(10);
        chk("dn0_e10", int'(duty_cycle), 15);
        adv(10);
        chk("dn0_e20", int'(duty_cycle), 10);
        adv(10);
        chk("dn0_e30", int'(duty_cycle), 5);
        adv(10);
        chk("dn0_e40", int'(duty_cycle), 0);
        chk("dn0_e40_done", int'(done), 1);
        do_accept(0);
        chk("eq_done", int'(done), 1);
        chk("eq_busy", int'(busy), 0);
        adv(1);
        chk("eq_done_end", int'(done), 0);

        // 0 -> 17 partial last step
        do_accept(17);
        adv(30);
        chk("up17_e30", int'(duty_cycle), 15);
        adv(9);
        chk("up17_e39", int'(duty_cycle), 15);
        adv(1);
        chk("up17_e40", int'(duty_cycle), 17);
        chk("up17_e40_done", int'(done), 1);

        // 150 clamps to 100 (17 -> 100 takes 17 ticks)
        do_accept(150);
        chk("clamp_pulse", int'(clamped), 1);
        adv(1);
        chk("clamp_pulse_end", int'(clamped), 0);
        wait_done(200, n);
        chk("clamp_done_edge", n, 169);
        chk("clamp_final", int'(duty_cycle), 100);
        do_accept(0);
        wait_done(250, n);
        chk("dn100_edge", n, 200);
        chk("dn100_final", int'(duty_cycle), 0);

        // abort ignored in IDLE
        abort = 1'b1;
        do_accept(5);
        abort = 1'b0;
        chk("idle_abort_busy", int'(busy), 1);
        adv(10);
        chk("idle_abort_duty", int'(duty_cycle), 5);
        chk("idle_abort_done", int'(done), 1);
        do_accept(0);
        wait_done(20, n);
        chk("back0_edge", n, 10);

        // 0 -> 50, abort on the e30 tick freezes at 10
        do_accept(50);
        adv(29);
        chk("ab_e29", int'(duty_cycle), 10);
        abort = 1'b1;
        adv(1);
        abort = 1'b0;
        chk("ab_duty", int'(duty_cycle), 10);
        chk("ab_busy", int'(busy), 0);
        chk("ab_ready", int'(tgt_ready), 1);
        chk("ab_done", int'(done), 0);
        adv(15);
        chk("ab_hold", int'(duty_cycle), 10);
        do_accept(0);
        wait_done(30, n);
        chk("ab_redn_edge", n, 20);
        chk("ab_redn_final", int'(duty_cycle), 0);

        // reset mid-ramp
        do_accept(60);
        adv(25);
        chk("mid_e25", int'(duty_cycle), 10);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_duty", int'(duty_cycle), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_ready", int'(tgt_ready), 1);
        adv(2);
        rst_n = 1'b1;
        adv(1);
        chk("mid_rel_duty", int'(duty_cycle), 0);
        chk("mid_rel_busy", int'(busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/duty_ramp_ctrl.md
Name: duty_ramp_ctrl

Overview:
Soft-start / slew-limited duty-cycle controller that feeds the duty_cycle input of the PWM generator. It accepts a target duty (percent, 0..MAX_DUTY) over a valid/ready handshake. It then steps its registered duty_cycle output toward the target at a fixed tick rate and step size. This keeps loads driven by the PWM stage (motors, LEDs) free of abrupt duty jumps.

Parameters:
CLK_FREQ, 50_000_000, clk frequency in Hz.
STEP_HZ, 1_000, ramp tick rate in Hz; TICK_DIV = CLK_FREQ / STEP_HZ clocks per tick, TICK_DIV >= 2.
STEP, 1, duty change per tick in percent; legal range 1..MAX_DUTY.
MAX_DUTY, 100, upper clamp for duty_cycle; MAX_DUTY <= 255.

Ports:
clk  input  1  system clock.
rst_n  input  1  asynchronous, active-low reset.
tgt_valid  input  1  target duty request valid.
tgt_ready  output  1  controller can accept a target; combinational, equals (state == IDLE).
tgt_duty  input  8  requested duty in percent.
abort  input  1  stop an in-progress ramp and hold the current duty.
duty_cycle  output  8  registered duty to the PWM generator.
busy  output  1  high while in RAMP_UP or RAMP_DOWN.
done  output  1  one-cycle pulse when duty_cycle reaches the target.
clamped  output  1  one-cycle pulse when an accepted target exceeded MAX_DUTY.

Behaviour:
- Reset is asynchronous, active-low (rst_n); clock is clk.
- Reset values: duty_cycle = 0, busy = 0, done = 0, clamped = 0, state = IDLE, tick counter = 0, target register = 0.
- Accept occurs when tgt_valid && tgt_ready. tgt_ready is high only in IDLE.
- On accept:
  - tgt = min(tgt_duty, MAX_DUTY).
  - clamped pulses on the following cycle if tgt_duty > MAX_DUTY.
  - The tick counter clears to 0.
- State transitions on accept:
  - tgt > duty_cycle → RAMP_UP.
  - tgt < duty_cycle → RAMP_DOWN.
  - tgt == duty_cycle → stay IDLE and pulse done on the next cycle.
- Tick counter runs only in RAMP states: 0..TICK_DIV-1, wraps to 0. The tick fires when the counter = TICK_DIV-1. The first step therefore lands TICK_DIV cycles after the accept edge.
- RAMP_UP on tick: duty_cycle += min(STEP, tgt - duty_cycle).
- RAMP_DOWN on tick: duty_cycle -= min(STEP, duty_cycle - tgt).
- Arithmetic uses 9-bit intermediates. duty_cycle never overshoots tgt, never underflows below 0, never exceeds MAX_DUTY.
- On the tick where duty_cycle becomes tgt:
  - In the same registered update, done = 1 for exactly one cycle and the state goes to IDLE.
  - busy is low from that cycle; tgt_ready is high in that cycle.
- Abort:
  - In a RAMP state, abort (sampled high) moves to IDLE next cycle. duty_cycle holds its current value and done is not pulsed.
  - If abort coincides with a tick, abort wins and no step is applied.
  - abort is ignored in IDLE.
- tgt_valid is ignored while busy; no queueing. A new target is accepted only in IDLE.
- duty_cycle changes only on tick, bypass load, or reset. It is glitch-free for the downstream PWM comparator.
- Reset asserted mid-ramp returns all outputs to reset values immediately.

Optional Feature:
Macro DUTY_RAMP_BYPASS_EN.
- Defined: adds port bypass (input, 1).
  - On accept with bypass = 1, duty_cycle loads the clamped tgt on the next cycle and done pulses in that same cycle.
  - State stays IDLE, with no ticks and busy = 0. clamped behaves as normal.
- Not defined: no bypass port; every accept ramps as above.

Test Plan:
All scenarios use CLK_FREQ=1000, STEP_HZ=100 (TICK_DIV=10), STEP=5, MAX_DUTY=100.
1. Reset pulse → duty_cycle=0, busy=0, done=0, clamped=0, tgt_ready=1 during and after reset.
2. From 0, accept tgt_duty=20 at edge 0 → duty_cycle 5/10/15/20 at edges 10/20/30/40; done pulses at edge 40 only; busy high for edges 1..39; tgt_valid ignored while busy.
3. From 0, accept 17 → 5/10/15 then 17 at edge 40 (partial step), done at 40, no overshoot.
4. From 20, accept 0 → 15/10/5/0 at edges 10..40, done at 40; then accept 0 again → no ramp, done pulse one cycle after accept.
5. Accept tgt_duty=150 → clamped pulse next cycle; ramp ends at duty_cycle=100 with done; duty_cycle never exceeds 100.
6. Ramp 0→50; assert abort when duty_cycle=10 (coinciding with a tick edge) → duty_cycle stays 10, no done, busy=0 and tgt_ready=1 next cycle; new accept of 0 then ramps down normally.
